// File: rtl/ot_pingpong_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ot_sched_pkg
// Purpose  : State encodings shared by the output-bank ping-pong scheduler.
// Revision : 1.0
// ============================================================================
package ot_sched_pkg;

    typedef logic [1:0] bank_st_t;
    localparam bank_st_t FREE  = 2'd0;
    localparam bank_st_t FILL  = 2'd1;
    localparam bank_st_t FULL  = 2'd2;
    localparam bank_st_t DRAIN = 2'd3;

    typedef logic [1:0] top_st_t;
    localparam top_st_t IDLE = 2'd0;
    localparam top_st_t RUN  = 2'd1;
    localparam top_st_t DONE = 2'd2;

    typedef logic [0:0] rd_st_t;
    localparam rd_st_t RD_IDLE = 1'b0;
    localparam rd_st_t RD_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ot_pingpong_sched_if.sv
`default_nettype none
// ============================================================================
// Interface: ot_pingpong_sched_if
// Purpose  : Layer control, write-back, read-engine and bank-port signals.
// Revision : 1.0
// ============================================================================
interface ot_pingpong_sched_if #(
    parameter int SRAM_DATA_BITS = 64,
    parameter int SRAM_ADDR_BITS = 10
);
    logic                      layer_start;
    logic [SRAM_ADDR_BITS-1:0] cfg_tile_numsub1;
    logic                      busy;
    logic                      layer_done;
    logic                      err_wr;

    logic                      wb_grant;
    logic                      wb_tile_start;
    logic                      wb_tile_done;
    logic                      wb_cen;
    logic                      wb_wen;
    logic [SRAM_ADDR_BITS-1:0] wb_addr;
    logic [SRAM_DATA_BITS-1:0] wb_data;

    logic                      rd_start;
    logic                      rd_done;
    logic                      rd_cen;
    logic                      rd_wen;
    logic [SRAM_ADDR_BITS-1:0] rd_addr;
    logic [SRAM_DATA_BITS-1:0] rd_data;

    logic                      cen_b0, wen_b0, cen_b1, wen_b1;
    logic [SRAM_ADDR_BITS-1:0] addr_b0, addr_b1;
    logic [SRAM_DATA_BITS-1:0] din_b0, din_b1;
    logic [SRAM_DATA_BITS-1:0] dout_b0, dout_b1;

    modport slave (
        input  layer_start, cfg_tile_numsub1,
        input  wb_tile_start, wb_tile_done, wb_cen, wb_wen, wb_addr, wb_data,
        input  rd_done, rd_cen, rd_wen, rd_addr,
        input  dout_b0, dout_b1,
        output busy, layer_done, err_wr, wb_grant, rd_start, rd_data,
        output cen_b0, wen_b0, addr_b0, din_b0,
        output cen_b1, wen_b1, addr_b1, din_b1
    );

    modport master (
        output layer_start, cfg_tile_numsub1,
        output wb_tile_start, wb_tile_done, wb_cen, wb_wen, wb_addr, wb_data,
        output rd_done, rd_cen, rd_wen, rd_addr,
        output dout_b0, dout_b1,
        input  busy, layer_done, err_wr, wb_grant, rd_start, rd_data,
        input  cen_b0, wen_b0, addr_b0, din_b0,
        input  cen_b1, wen_b1, addr_b1, din_b1
    );
endinterface
`default_nettype wire

// File: rtl/ot_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ot_bank_ctrl
// Purpose  : One output bank: ownership state register plus its SRAM port mux.
// Revision : 1.0
// ============================================================================
module ot_bank_ctrl
    import ot_sched_pkg::*;
#(
    parameter int SRAM_DATA_BITS = 64,
    parameter int SRAM_ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_fill,
    input  logic                      set_full,
    input  logic                      set_drain,
    input  logic                      set_free,
    input  logic                      wb_cen,
    input  logic                      wb_wen,
    input  logic [SRAM_ADDR_BITS-1:0] wb_addr,
    input  logic [SRAM_DATA_BITS-1:0] wb_data,
    input  logic                      rd_cen,
    input  logic                      rd_wen,
    input  logic [SRAM_ADDR_BITS-1:0] rd_addr,
    output bank_st_t                  state,
    output logic                      cen,
    output logic                      wen,
    output logic [SRAM_ADDR_BITS-1:0] addr,
    output logic [SRAM_DATA_BITS-1:0] din
);
    bank_st_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FREE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (set_free)       state_d = FREE;
        else if (set_fill)  state_d = FILL;
        else if (set_full)  state_d = FULL;
        else if (set_drain) state_d = DRAIN;
    end

    // The mux follows the registered state so the SRAM path adds no latency.
    always_comb begin
        cen  = 1'b1;
        wen  = 1'b1;
        addr = '0;
        din  = '0;
        case (state_q)
            FILL: begin
                cen  = wb_cen;
                wen  = wb_wen;
                addr = wb_addr;
                din  = wb_data;
            end
            DRAIN: begin
                cen  = rd_cen;
                wen  = rd_wen;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign state = state_q;
endmodule
`default_nettype wire

// File: rtl/ot_pingpong_sched.sv
`default_nettype none
// ============================================================================
// Module   : ot_pingpong_sched
// Purpose  : Alternates two output SRAM banks between PE write-back and the
//            output read engine for one layer of tiles.
// Revision : 1.0
// ============================================================================
module ot_pingpong_sched
    import ot_sched_pkg::*;
#(
    parameter int SRAM_DATA_BITS = 64,
    parameter int SRAM_ADDR_BITS = 10
) (
    input  logic               clk,
    input  logic               reset,
    ot_pingpong_sched_if.slave bus
);
    localparam logic [SRAM_ADDR_BITS-1:0] c_one = SRAM_ADDR_BITS'(1);

    top_st_t top_q, top_d;
    rd_st_t  rds_q, rds_d;
    logic    wb_ptr_q, wb_ptr_d, rd_ptr_q, rd_ptr_d, rd_sel_q, rd_sel_d;
    logic    all_issued_q, all_issued_d, err_q, err_d, rd_start_q, rd_start_d;
    logic [SRAM_ADDR_BITS-1:0] fill_cnt_q, fill_cnt_d, drain_cnt_q, drain_cnt_d;
    logic [SRAM_ADDR_BITS-1:0] cfg_q, cfg_d;

    bank_st_t                  st     [2];
    logic [1:0]                set_fill, set_full, set_drain, set_free;
    logic [1:0]                b_cen, b_wen;
    logic [SRAM_ADDR_BITS-1:0] b_addr [2];
    logic [SRAM_DATA_BITS-1:0] b_din  [2];

    logic run, layer_go, grant, fill_go, full_go, rd_issue, drain_done, err_set;

    // Decodes use registered state only; wb_grant therefore has no input path.
    assign run        = (top_q == RUN);
    assign layer_go   = (top_q == IDLE) && bus.layer_start;
    assign grant      = run && (st[wb_ptr_q] == FREE) && !all_issued_q;
    assign fill_go    = bus.wb_tile_start && grant;
    assign full_go    = bus.wb_tile_done && (st[wb_ptr_q] == FILL);
    assign rd_issue   = run && (rds_q == RD_IDLE) && (st[rd_ptr_q] == FULL);
    assign drain_done = (rds_q == RD_WAIT) && bus.rd_done;
    assign err_set    = (bus.wb_tile_start && !grant)
                     || (bus.wb_tile_done && !full_go)
                     || (!bus.wb_cen && (st[0] != FILL) && (st[1] != FILL));

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q        <= IDLE;
            rds_q        <= RD_IDLE;
            wb_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            all_issued_q <= 1'b0;
            err_q        <= 1'b0;
            rd_start_q   <= 1'b0;
            fill_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            cfg_q        <= '0;
        end else begin
            top_q        <= top_d;
            rds_q        <= rds_d;
            wb_ptr_q     <= wb_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_sel_q     <= rd_sel_d;
            all_issued_q <= all_issued_d;
            err_q        <= err_d;
            rd_start_q   <= rd_start_d;
            fill_cnt_q   <= fill_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            cfg_q        <= cfg_d;
        end
    end

    always_comb begin
        top_d = top_q;
        case (top_q)
            IDLE:    if (bus.layer_start) top_d = RUN;
            RUN:     if (drain_done && (drain_cnt_q == cfg_q)) top_d = DONE;
            default: top_d = IDLE;
        endcase
        rds_d = rds_q;
        case (rds_q)
            RD_IDLE: if (rd_issue) rds_d = RD_WAIT;
            default: if (bus.rd_done) rds_d = RD_IDLE;
        endcase
    end

    always_comb begin
        cfg_d        = cfg_q;
        wb_ptr_d     = wb_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        all_issued_d = all_issued_q;
        err_d        = err_q | err_set;
        rd_sel_d     = rd_issue ? rd_ptr_q : rd_sel_q;
        rd_start_d   = rd_issue;
        if (layer_go) begin
            cfg_d        = bus.cfg_tile_numsub1;
            wb_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            fill_cnt_d   = '0;
            drain_cnt_d  = '0;
            all_issued_d = 1'b0;
            err_d        = 1'b0;
        end else begin
            if (fill_go) begin
                fill_cnt_d = fill_cnt_q + c_one;
                if (fill_cnt_q == cfg_q) all_issued_d = 1'b1;
            end
            if (full_go) wb_ptr_d = ~wb_ptr_q;
            if (drain_done) begin
                rd_ptr_d    = ~rd_ptr_q;
                drain_cnt_d = drain_cnt_q + c_one;
            end
        end
    end

    always_comb begin
        set_fill  = '0;
        set_full  = '0;
        set_drain = '0;
        set_free  = '0;
        for (int b = 0; b < 2; b++) begin
            set_fill[b]  = fill_go    && (wb_ptr_q == 1'(b));
            set_full[b]  = full_go    && (wb_ptr_q == 1'(b));
            set_drain[b] = rd_issue   && (rd_ptr_q == 1'(b));
            set_free[b]  = layer_go || (drain_done && (rd_ptr_q == 1'(b)));
        end
        bus.busy       = (top_q == RUN) || (top_q == DONE);
        bus.layer_done = (top_q == DONE);
        bus.err_wr     = err_q;
        bus.wb_grant   = grant;
        bus.rd_start   = rd_start_q;
        bus.rd_data    = rd_sel_q ? bus.dout_b1 : bus.dout_b0;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        ot_bank_ctrl #(
            .SRAM_DATA_BITS (SRAM_DATA_BITS),
            .SRAM_ADDR_BITS (SRAM_ADDR_BITS)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .set_fill  (set_fill[gi]),
            .set_full  (set_full[gi]),
            .set_drain (set_drain[gi]),
            .set_free  (set_free[gi]),
            .wb_cen    (bus.wb_cen),
            .wb_wen    (bus.wb_wen),
            .wb_addr   (bus.wb_addr),
            .wb_data   (bus.wb_data),
            .rd_cen    (bus.rd_cen),
            .rd_wen    (bus.rd_wen),
            .rd_addr   (bus.rd_addr),
            .state     (st[gi]),
            .cen       (b_cen[gi]),
            .wen       (b_wen[gi]),
            .addr      (b_addr[gi]),
            .din       (b_din[gi])
        );
    end

    assign bus.cen_b0  = b_cen[0];
    assign bus.wen_b0  = b_wen[0];
    assign bus.addr_b0 = b_addr[0];
    assign bus.din_b0  = b_din[0];
    assign bus.cen_b1  = b_cen[1];
    assign bus.wen_b1  = b_wen[1];
    assign bus.addr_b1 = b_addr[1];
    assign bus.din_b1  = b_din[1];
endmodule
`default_nettype wire

// File: tb/tb_ot_pingpong_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ot_pingpong_sched
// Purpose  : Directed self-checking bench with SRAM models and a data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ot_pingpong_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ot_pingpong_sched_if #(.SRAM_DATA_BITS(64), .SRAM_ADDR_BITS(10)) bus ();

    ot_pingpong_sched #(.SRAM_DATA_BITS(64), .SRAM_ADDR_BITS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port SRAM models, one-cycle read latency.
    logic [63:0] mem0 [16];
    logic [63:0] mem1 [16];
    logic [63:0] dout0_r = 64'hA0A0_A0A0_A0A0_A0A0;
    logic [63:0] dout1_r = 64'hB1B1_B1B1_B1B1_B1B1;
    always @(posedge clk) begin
        if (bus.cen_b0 == 1'b0) begin
            if (bus.wen_b0 == 1'b0) mem0[bus.addr_b0[3:0]] <= bus.din_b0;
            else                    dout0_r <= mem0[bus.addr_b0[3:0]];
        end
        if (bus.cen_b1 == 1'b0) begin
            if (bus.wen_b1 == 1'b0) mem1[bus.addr_b1[3:0]] <= bus.din_b1;
            else                    dout1_r <= mem1[bus.addr_b1[3:0]];
        end
    end
    assign bus.dout_b0 = dout0_r;
    assign bus.dout_b1 = dout1_r;

    int n_rd_start = 0;
    int n_layer_done = 0;
    always @(negedge clk) begin
        if (bus.rd_start === 1'b1)   n_rd_start   <= n_rd_start + 1;
        if (bus.layer_done === 1'b1) n_layer_done <= n_layer_done + 1;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_used = 0;
    int          base_rs, base_ld;
    logic        wb_ptr_m;
    logic [63:0] sb_q [$];
    logic        bank_q [$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic bank_cen(input logic b);
        return b ? bus.cen_b1 : bus.cen_b0;
    endfunction

    task automatic check_reset_vals(input logic [63:0] exp_rd);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_layer_done", bus.layer_done, 1'b0);
        chk1("rst_rd_start", bus.rd_start, 1'b0);
        chk1("rst_wb_grant", bus.wb_grant, 1'b0);
        chk1("rst_err_wr", bus.err_wr, 1'b0);
        chk1("rst_cen_b0", bus.cen_b0, 1'b1);
        chk1("rst_cen_b1", bus.cen_b1, 1'b1);
        chk1("rst_wen_b0", bus.wen_b0, 1'b1);
        chk1("rst_wen_b1", bus.wen_b1, 1'b1);
        chk64("rst_addr_b0", 64'(bus.addr_b0), 64'd0);
        chk64("rst_addr_b1", 64'(bus.addr_b1), 64'd0);
        chk64("rst_din_b0", bus.din_b0, 64'd0);
        chk64("rst_din_b1", bus.din_b1, 64'd0);
        chk64("rst_rd_data", bus.rd_data, exp_rd);
    endtask

    task automatic start_layer(input logic [9:0] cfg);
        bus.cfg_tile_numsub1 = cfg;
        bus.layer_start = 1'b1;
        tick();
        bus.layer_start = 1'b0;
        wb_ptr_m = 1'b0;
        rd_used  = n_rd_start;
        base_rs  = n_rd_start;
        base_ld  = n_layer_done;
        chk1("start_busy", bus.busy, 1'b1);
        chk1("start_err_clear", bus.err_wr, 1'b0);
    endtask

    task automatic tile_done();
        bus.wb_tile_done = 1'b1;
        tick();
        bus.wb_tile_done = 1'b0;
        wb_ptr_m = ~wb_ptr_m;
    endtask

    task automatic write_tile(input int nw, input logic [63:0] base, input bit do_done);
        int k = 0;
        while (bus.wb_grant !== 1'b1 && k < 200) begin tick(); k++; end
        chk1("wb_grant_wait", bus.wb_grant, 1'b1);
        bus.wb_tile_start = 1'b1;
        tick();
        bus.wb_tile_start = 1'b0;
        bank_q.push_back(wb_ptr_m);
        for (int i = 0; i < nw; i++) begin
            bus.wb_cen  = 1'b0;
            bus.wb_wen  = 1'b0;
            bus.wb_addr = 10'(i);
            bus.wb_data = base + 64'(i);
            sb_q.push_back(base + 64'(i));
            if (i == 0) begin
                settle();
                chk1("wb_bank_cen", bank_cen(wb_ptr_m), 1'b0);
            end
            tick();
        end
        bus.wb_cen = 1'b1;
        bus.wb_wen = 1'b1;
        if (do_done) tile_done();
    endtask

    task automatic read_tile(input int nw, input bit do_done);
        int   k = 0;
        logic b;
        while ((n_rd_start - rd_used) == 0 && k < 200) begin tick(); k++; end
        chk1("rd_start_wait", (n_rd_start - rd_used) != 0, 1'b1);
        rd_used++;
        b = bank_q.pop_front();
        for (int i = 0; i < nw; i++) begin
            bus.rd_cen  = 1'b0;
            bus.rd_wen  = 1'b1;
            bus.rd_addr = 10'(i);
            settle();
            if (i == 0) chk1("rd_bank_cen", bank_cen(b), 1'b0);
            tick();
            bus.rd_cen = 1'b1;
            settle();
            chk64("rd_data", bus.rd_data, sb_q.pop_front());
        end
        if (do_done) begin
            bus.rd_done = 1'b1;
            tick();
            bus.rd_done = 1'b0;
        end
    endtask

    task automatic finish_layer();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        chk1("layer_done_m1", bus.layer_done, 1'b1);
        chk1("busy_m1", bus.busy, 1'b1);
        tick();
        chk1("busy_m2", bus.busy, 1'b0);
        chk1("layer_done_m2", bus.layer_done, 1'b0);
    endtask

    task automatic run_four(input logic [63:0] base);
        start_layer(10'd3);
        write_tile(8, base + 64'h000, 1);
        write_tile(8, base + 64'h100, 1);
        chk1("grant_both_busy", bus.wb_grant, 1'b0);
        read_tile(8, 1);
        chk1("grant_after_free", bus.wb_grant, 1'b1);
        write_tile(8, base + 64'h200, 1);
        read_tile(8, 1);
        write_tile(8, base + 64'h300, 1);
        read_tile(8, 1);
        read_tile(8, 0);
        finish_layer();
        chk64("four_rd_starts", 64'(n_rd_start - base_rs), 64'd4);
        chk64("four_layer_done", 64'(n_layer_done - base_ld), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.layer_start = 1'b0;  bus.cfg_tile_numsub1 = '0;
        bus.wb_tile_start = 1'b0; bus.wb_tile_done = 1'b0;
        bus.wb_cen = 1'b1; bus.wb_wen = 1'b1; bus.wb_addr = '0; bus.wb_data = '0;
        bus.rd_done = 1'b0; bus.rd_cen = 1'b1; bus.rd_wen = 1'b1; bus.rd_addr = '0;
        tick(); tick();
        check_reset_vals(dout0_r);
        reset = 1'b0;
        tick();

        // Single tile: rd_start two cycles after wb_tile_done, layer_done one after rd_done.
        start_layer(10'd0);
        chk1("single_grant", bus.wb_grant, 1'b1);
        write_tile(8, 64'h1000, 0);
        tile_done();
        chk1("single_rd_start_n1", bus.rd_start, 1'b0);
        chk1("single_grant_all_issued", bus.wb_grant, 1'b0);
        tick();
        chk1("single_rd_start_n2", bus.rd_start, 1'b1);
        read_tile(8, 0);
        finish_layer();

        // Protocol errors while bank0 drains and nothing is filling.
        start_layer(10'd0);
        write_tile(4, 64'h2000, 1);
        tick();
        chk1("err_before", bus.err_wr, 1'b0);
        bus.wb_tile_start = 1'b1;
        bus.wb_cen  = 1'b0;
        bus.wb_wen  = 1'b0;
        bus.wb_addr = 10'd5;
        bus.wb_data = 64'hDEAD;
        settle();
        chk1("err_cen_b0", bus.cen_b0, 1'b1);
        chk1("err_cen_b1", bus.cen_b1, 1'b1);
        chk1("err_wen_b1", bus.wen_b1, 1'b1);
        tick();
        bus.wb_tile_start = 1'b0;
        bus.wb_cen = 1'b1;
        bus.wb_wen = 1'b1;
        chk1("err_set", bus.err_wr, 1'b1);
        chk1("err_grant_stays", bus.wb_grant, 1'b0);
        read_tile(4, 0);
        finish_layer();
        chk1("err_sticky", bus.err_wr, 1'b1);

        // Four tiles, writer ahead of reader.
        run_four(64'h3000);

        // Same-edge wb_tile_done on bank1 and rd_done on bank0.
        start_layer(10'd2);
        write_tile(8, 64'h4000, 1);
        write_tile(8, 64'h4100, 0);
        read_tile(8, 0);
        bus.wb_tile_done = 1'b1;
        bus.rd_done      = 1'b1;
        tick();
        bus.wb_tile_done = 1'b0;
        bus.rd_done      = 1'b0;
        wb_ptr_m = ~wb_ptr_m;
        chk1("sim_grant_bank0_free", bus.wb_grant, 1'b1);
        chk1("sim_rd_start_m1", bus.rd_start, 1'b0);
        tick();
        chk1("sim_rd_start_m2", bus.rd_start, 1'b1);
        write_tile(8, 64'h4200, 1);
        read_tile(8, 1);
        read_tile(8, 0);
        finish_layer();

        // Reset while tile 2 of 4 is draining, then a clean rerun.
        start_layer(10'd3);
        write_tile(8, 64'h5000, 1);
        read_tile(8, 1);
        write_tile(8, 64'h5100, 1);
        read_tile(3, 0);
        reset = 1'b1;
        tick();
        check_reset_vals(dout0_r);
        sb_q.delete();
        bank_q.delete();
        reset = 1'b0;
        tick();
        run_four(64'h6000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ot_pingpong_sched.md
# ot_pingpong_sched

Ping-pong scheduler for the two output SRAM banks. It lets PE write-back fill one bank while the output read engine drains the other into the output FIFO. It sits between the PE write-back path, the output read engine (start/busy/done plus SRAM read port) and two single-port output SRAM macros. It sequences one layer of `cfg_tile_numsub1+1` tiles and muxes each bank's port to its current owner.

## Interface
Parameters:
- `SRAM_DATA_BITS`, 64, width of SRAM word.
- `SRAM_ADDR_BITS`, 10, width of SRAM address and of the tile counters.

Ports:
- Clocking and reset:
  - `clk` in 1: single clock.
  - `reset` in 1: synchronous, active-high.
- Layer control:
  - `layer_start` in 1: pulse; starts a layer.
  - `cfg_tile_numsub1` in SRAM_ADDR_BITS: tiles per layer minus 1; sampled on an accepted `layer_start`.
  - `busy` out 1: high in RUN and DONE.
  - `layer_done` out 1: one-cycle pulse when the last tile has drained.
  - `err_wr` out 1: sticky write-protocol error; cleared by `reset` or an accepted `layer_start`.
- Write-back side:
  - `wb_grant` out 1: a FREE bank is available for a new tile.
  - `wb_tile_start` in 1: pulse; writer begins a tile.
  - `wb_tile_done` in 1: pulse; writer finished the tile.
  - `wb_cen`, `wb_wen` in 1 each: active-low enables.
  - `wb_addr` in SRAM_ADDR_BITS.
  - `wb_data` in SRAM_DATA_BITS.
- Read-engine side:
  - `rd_start` out 1: one-cycle start pulse.
  - `rd_done` in 1: pulse from the read engine.
  - `rd_cen`, `rd_wen` in 1 each.
  - `rd_addr` in SRAM_ADDR_BITS.
  - `rd_data` out SRAM_DATA_BITS: muxed bank read data.
- Bank ports, for n = 0, 1:
  - `cen_b<n>`, `wen_b<n>` out 1 each.
  - `addr_b<n>` out SRAM_ADDR_BITS.
  - `din_b<n>` out SRAM_DATA_BITS.
  - `dout_b<n>` in SRAM_DATA_BITS.

## Operation
- Top FSM:
  - IDLE→RUN on `layer_start`. On entry: both banks FREE, `wb_ptr`=`rd_ptr`=0, `fill_cnt`=`drain_cnt`=0, `all_issued`=0, `err_wr`=0.
  - RUN→DONE when `rd_done` arrives and `drain_cnt`==`cfg_tile_numsub1`.
  - DONE→IDLE unconditionally. `layer_done`=1 only in DONE.
  - `layer_start` outside IDLE is ignored.
- Bank state, per bank, 2 bits: FREE(0), FILL(1), FULL(2), DRAIN(3).
  - FREE→FILL: `wb_tile_start` while `wb_grant`, on bank[`wb_ptr`]. At the same edge, `fill_cnt`++ and `all_issued` is set if `fill_cnt`==`cfg_tile_numsub1`.
  - FILL→FULL: `wb_tile_done`, on bank[`wb_ptr`]; `wb_ptr` toggles.
  - FULL→DRAIN: issue of `rd_start`.
  - DRAIN→FREE: `rd_done`; `rd_ptr` toggles, `drain_cnt`++.
- `wb_grant` = RUN & bank[`wb_ptr`]==FREE & !`all_issued`. It is decoded from registers only, with no input paths.
- Read scheduler FSM, RD_IDLE/RD_WAIT:
  - In RD_IDLE with top RUN and bank[`rd_ptr`]==FULL: register `rd_start`=1, move the bank to DRAIN, load `rd_sel`←`rd_ptr`, go to RD_WAIT.
  - RD_WAIT→RD_IDLE on `rd_done`.
- Port mux, per bank:
  - FILL: driven by `wb_*` (`din` = `wb_data`).
  - DRAIN: driven by `rd_*`.
  - Otherwise: `cen`=1, `wen`=1, `addr`=0, `din`=0.
- `rd_data` = `dout_b[rd_sel]`. `rd_sel` changes only at the next `rd_start`, so the read engine's delayed data capture after `rd_done` stays correct.
- Errors set `err_wr`:
  - `wb_tile_start` without `wb_grant`: ignored, sets `err_wr`.
  - `wb_tile_done` with bank[`wb_ptr`]≠FILL: ignored, sets `err_wr`.
  - `wb_cen`=0 with no bank in FILL: access dropped, sets `err_wr`.
  - Spurious `rd_done` in RD_IDLE: ignored.

## Timing
- Reset values: `busy`, `layer_done`, `rd_start`, `wb_grant`, `err_wr` = 0; `cen_b*`=`wen_b*`=1; `addr_b*`, `din_b*` = 0; `rd_sel`=0, so `rd_data`=`dout_b0`.
- `reset` mid-layer aborts at the next edge: all FSMs IDLE, banks FREE, counters 0. No `layer_done`.
- Port mux is combinational from bank state; zero added latency on SRAM address/data.
- `wb_tile_done` in cycle N: FULL visible in N+1, `rd_start` high in N+2, bank in DRAIN and owned by the reader from N+2.
- `rd_done` in cycle M:
  - Bank FREE and `wb_grant` possible in M+1.
  - If the other bank is FULL, `rd_start` high in M+2.
  - If this was the last tile, `layer_done` high in M+1 and IDLE in M+2.
- Simultaneous `wb_tile_done` and `rd_done` on different banks: both take effect at the same edge.
- `wb_tile_start` and `rd_done` freeing the same bank in the same cycle: the start is rejected, because the grant reflects the registered state.
- Layer with `cfg_tile_numsub1`=0: exactly one fill and one drain, then `layer_done`.

## Structure
- Shared package `ot_sched_pkg`:
  - Bank state encodings FREE/FILL/FULL/DRAIN.
  - Top FSM encodings IDLE/RUN/DONE.
  - Read FSM encodings RD_IDLE/RD_WAIT.
- One natural sub-module, `ot_bank_ctrl`, instantiated twice: the per-bank state register plus its port mux. Inputs are set_fill/set_full/set_drain/set_free and the wb/rd port buses; outputs are the state and the bank port.
- Top level holds the pointers, counters, both FSMs and the `rd_data` mux.

## Test plan
- Single tile (`cfg_tile_numsub1`=0): start; write 8 words to bank0; `wb_tile_done` at N → `rd_start` at N+2. Reader sees bank0 data on `rd_data`; `rd_done` at M → `layer_done` at M+1, `busy`=0 at M+2.
- Four tiles, writer faster than reader: `wb_grant` drops while both banks are non-FREE. Banks alternate 0,1,0,1. Exactly 4 `rd_start` pulses and one `layer_done`.
- Same-cycle `wb_tile_done`(bank1) and `rd_done`(bank0): bank1 FULL, bank0 FREE at the next edge; `rd_start` for bank1 two cycles later.
- Protocol errors: `wb_tile_start` with `wb_grant`=0, and `wb_cen`=0 with no FILL bank → `err_wr`=1, bank states unchanged, no SRAM enable asserted.
- `reset` asserted mid-drain of tile 2 of 4 → next cycle all outputs at reset values. A new `layer_start` runs 4 tiles cleanly.
